// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared sizing and VC encoding for the cardinal output arbiter
package cardinal_pkg;
  localparam int PAC_WIDTH = 64;
  localparam int NUM_REQ = 3;
  localparam int VC_BIT = 0;
  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;
endpackage

// File: rtl/cardinal_out_arb_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with registered priority pointer and enable
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [0:N-1] i_req,
  output logic [0:N-1] o_gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] r_ptr, w_nxt;
  logic          w_hit;
  function automatic int wrap(input int a);
    return (a >= N) ? a - N : a;
  endfunction
  // Scan from the pointer; first requester found wins and the pointer moves past it
  always_comb begin
    o_gnt = '0;
    w_hit = 1'b0;
    w_nxt = r_ptr;
    for (int j = 0; j < N; j++) begin
      if (!w_hit && i_en && i_req[wrap(int'(r_ptr) + j)]) begin
        w_hit = 1'b1;
        o_gnt[wrap(int'(r_ptr) + j)] = 1'b1;
        w_nxt = PW'(wrap(int'(r_ptr) + j + 1));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) r_ptr <= '0;
    else r_ptr <= w_nxt;
  end
endmodule

// File: rtl/cardinal_out_arb.sv
// cardinal_out_arb: two single-entry VC output buffers fed by round-robin grants,
// drained one VC at a time as selected by router polarity
module cardinal_out_arb #(
  parameter int PAC_WIDTH = cardinal_pkg::PAC_WIDTH,
  parameter int NUM_REQ = cardinal_pkg::NUM_REQ
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [0:NUM_REQ-1]         req,
  input  logic [0:NUM_REQ*PAC_WIDTH-1] req_data,
  output logic [0:NUM_REQ-1]         gnt,
  input  logic                       polarity,
  output logic                       out_so,
  input  logic                       out_ro,
  output logic [0:PAC_WIDTH-1]       out_do,
  output logic [0:1]                 vc_full
);
  import cardinal_pkg::*;
  logic [0:1][0:NUM_REQ-1]   w_req, w_gnt;
  logic [0:1][0:PAC_WIDTH-1] w_pkt, r_data;
  logic [0:1]                r_full;
  logic                      w_dv, w_so;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[0][i] = req[i] & (req_data[i*PAC_WIDTH+VC_BIT] == VC0);
      w_req[1][i] = req[i] & (req_data[i*PAC_WIDTH+VC_BIT] == VC1);
    end
  end
  genvar v;
  generate
    for (v = 0; v < 2; v++) begin : g_vc
      rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .reset (reset),
        .i_en  (reset & ~r_full[v]),
        .i_req (w_req[v]),
        .o_gnt (w_gnt[v])
      );
    end
  endgenerate
  always_comb begin
    w_pkt = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (w_gnt[k][i]) w_pkt[k] = req_data[i*PAC_WIDTH +: PAC_WIDTH];
  end
  assign w_dv = polarity ? VC0 : VC1;
  assign w_so = reset & r_full[w_dv] & out_ro;
  // A VC only loads while empty and only drains while full, so both never hit one buffer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full <= '0;
      r_data <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (|w_gnt[k]) begin
          r_full[k] <= 1'b1;
          r_data[k] <= w_pkt[k];
        end else if (w_so && w_dv == 1'(k)) r_full[k] <= 1'b0;
      end
    end
  end
  assign gnt = w_gnt[0] | w_gnt[1];
  assign out_so = w_so;
  assign out_do = w_so ? r_data[w_dv] : '0;
  assign vc_full = reset ? r_full : 2'b00;
endmodule

// File: doc/cardinal_out_arb.md
CARDINAL_OUT_ARB -- requirements
Module: cardinal_out_arb

Interface
REQ-001 Parameter PAC_WIDTH, default 64, packet width in bits; bit 0 of every packet is the VC bit.
REQ-002 Parameter NUM_REQ, default 3, number of requesting input buffers.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  [0:NUM_REQ-1]  requester i holds a packet (its buffer is full).
REQ-006 req_data  input  [0:NUM_REQ*PAC_WIDTH-1]  requester i packet in slice [i*PAC_WIDTH +: PAC_WIDTH].
REQ-007 gnt  output  [0:NUM_REQ-1]  pop strobe: requester i's packet is accepted this cycle.
REQ-008 polarity  input  1  router polarity, toggles each cycle.
REQ-009 out_so  output  1  send handshake to the downstream channel.
REQ-010 out_ro  input  1  ready handshake from the downstream channel.
REQ-011 out_do  output  [0:PAC_WIDTH-1]  packet to the downstream channel.
REQ-012 vc_full  output  [0:1]  occupancy flag of output buffer VC0 and VC1.

Function
REQ-013 The block SHALL hold two single-entry output buffers, one per VC, each with a data register and a full flag.
REQ-014 Requester i SHALL request VC v when req[i]=1 and bit 0 of its packet equals v; each requester requests at most one VC per cycle.
REQ-015 For each VC whose buffer is empty at the start of the cycle, a round-robin choice among its requesters SHALL assert exactly one gnt bit combinationally in the same cycle.
REQ-016 The buffer SHALL load the granted packet at the next rising edge and set its full flag; load latency is 1 cycle.
REQ-017 A VC whose buffer is full SHALL issue no grant, including in a cycle where that buffer drains.
REQ-018 Both VCs MAY grant different requesters in the same cycle; gnt SHALL then carry two bits set.
REQ-019 Round-robin pointer per VC: after a grant to requester k, priority order SHALL start at (k+1) mod NUM_REQ; with no grant the pointer SHALL be unchanged.
REQ-020 Drain VC SHALL be VC0 when polarity=1 and VC1 when polarity=0.
REQ-021 out_so SHALL equal (drain-VC full flag AND out_ro), combinationally.
REQ-022 out_do SHALL equal the drain-VC buffer data when out_so=1 and all-zeros otherwise.
REQ-023 When out_so=1 the drain-VC full flag SHALL clear at the next edge.
REQ-024 When out_ro=0 or the drain VC is empty, buffer contents SHALL be held and out_so=0.
REQ-025 Because fill and drain of one VC never coincide, a VC sustains one packet every two cycles under alternating polarity.
REQ-026 When req=0, gnt SHALL be 0 and no state SHALL change except draining.

Reset
REQ-027 When reset=0 at a rising edge, both full flags, both data registers and both round-robin pointers SHALL go to 0; requester 0 has highest priority.
REQ-028 While reset=0, gnt, out_so, out_do and vc_full SHALL be 0.
REQ-029 Reset mid-operation SHALL discard buffered packets without a send handshake.

Structure
REQ-030 A shared package cardinal_pkg SHALL hold PAC_WIDTH, NUM_REQ, the VC bit index (0) and VC encoding constants (VC0=0, VC1=1).
REQ-031 A sub-module rr_arbiter (NUM_REQ-way round-robin with registered pointer, enable input) SHALL be instantiated once per VC.
REQ-032 Estimated RTL size: 150-250 lines total.

Verification
REQ-033 Reset then release, req=000 -> gnt=000, out_so=0, vc_full=00, out_do=0 for 10 cycles.
REQ-034 req=111, all packets VC0, out_ro=1, polarity toggling -> grants in order 0,1,2,0; each packet appears on out_do with out_so=1 only in polarity=1 cycles.
REQ-035 req0 packet VC0 and req1 packet VC1 in the same cycle, both buffers empty -> gnt=110, vc_full=11 next cycle.
REQ-036 VC1 buffer full, out_ro=0 for 5 cycles -> out_so=0, vc_full[1] stays 1, no gnt to any VC1 requester; out_ro=1 with polarity=0 -> out_so=1, vc_full[1]=0 next cycle.
REQ-037 reset=0 asserted while both buffers full -> vc_full=00 next cycle, no out_so pulse; first grant after release goes to requester 0.
REQ-038 Only req2 active (VC0) for 4 packets -> gnt[2] every other cycle, pointer wraps to 0 each time, no gnt to idle requesters.
